// File: rtl/thirty_two_bit_seq_subtractor_pkg.sv
// Shared definitions for the sequential 32-bit subtractor: FSM encoding,
// datapath widths and the latched operand bundle.
package thirty_two_bit_seq_subtractor_pkg;

  localparam int WIDTH = 32;
  localparam int HALF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Operands captured on an accepted start
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
  } opnd_t;

endpackage

// File: rtl/sixteen_bit_vedic_subtractor.sv
// Combinational 16-bit slice: out = in1 - in2 - bin, realised as
// in1 + ~in2 + ~bin so a single adder is used; borrow is the inverted carry.
module sixteen_bit_vedic_subtractor
  import thirty_two_bit_seq_subtractor_pkg::*;
(
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        bin,
  output logic [15:0] out,
  output logic        bout
);

  logic [HALF:0] sum;

  // One's-complement add; carry-out of 1 means no borrow was needed
  always_comb begin
    sum  = {1'b0, in1} + {1'b0, ~in2} + {{HALF{1'b0}}, ~bin};
    out  = sum[HALF-1:0];
    bout = ~sum[HALF];
  end

endmodule

// File: rtl/thirty_two_bit_seq_subtractor.sv
// Sequential 32-bit subtractor that time-shares one 16-bit slice:
// low half in LOW, high half (with the low borrow) in HIGH, result in DONE.
module thirty_two_bit_seq_subtractor
  import thirty_two_bit_seq_subtractor_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        bin,
  output logic [31:0] diff,
  output logic        bout,
  output logic        ovf,
  output logic        busy,
  output logic        done
);

  state_t             state_q, state_d;
  opnd_t              opnd_q, opnd_d;
  logic               b16_q, b16_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;

  logic [HALF-1:0]    slice_a, slice_b, slice_out;
  logic               slice_bin, slice_bout;
  logic               accept;

  // Start is only honoured when not busy (IDLE or DONE)
  assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = accept ? ST_LOW : ST_IDLE;
      ST_LOW:  state_d = ST_HIGH;
      ST_HIGH: state_d = ST_DONE;
      ST_DONE: state_d = accept ? ST_LOW : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state_q == ST_LOW) || (state_q == ST_HIGH);
    done = (state_q == ST_DONE);
  end

  // Slice operand select: low halves with bin in LOW, high halves with b16 otherwise
  always_comb begin
    if (state_q == ST_LOW) begin
      slice_a   = opnd_q.a[HALF-1:0];
      slice_b   = opnd_q.b[HALF-1:0];
      slice_bin = opnd_q.bin;
    end else begin
      slice_a   = opnd_q.a[WIDTH-1:HALF];
      slice_b   = opnd_q.b[WIDTH-1:HALF];
      slice_bin = b16_q;
    end
  end

  sixteen_bit_vedic_subtractor u_slice (
    .in1  (slice_a),
    .in2  (slice_b),
    .bin  (slice_bin),
    .out  (slice_out),
    .bout (slice_bout)
  );

  // Datapath next values: capture operands on accept, fill result halves in LOW/HIGH
  always_comb begin
    opnd_d = opnd_q;
    b16_d  = b16_q;
    diff_d = diff_q;
    bout_d = bout_q;
    ovf_d  = ovf_q;
    if (accept) begin
      opnd_d.a   = in1;
      opnd_d.b   = in2;
      opnd_d.bin = bin;
    end
    case (state_q)
      ST_LOW: begin
        diff_d[HALF-1:0] = slice_out;
        b16_d            = slice_bout;
      end
      ST_HIGH: begin
        diff_d[WIDTH-1:HALF] = slice_out;
        bout_d               = slice_bout;
        // Overflow only possible when operand signs differ and result sign flips from in1
        ovf_d = (opnd_q.a[WIDTH-1] != opnd_q.b[WIDTH-1]) &&
                (slice_out[HALF-1] != opnd_q.a[WIDTH-1]);
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q <= '0;
      b16_q  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      opnd_q <= opnd_d;
      b16_q  <= b16_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule
